// File: rtl/multi_run_detect_pkg.sv
// Shared types and helpers for the multi-channel run-length qualifier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   mode_e       - polarity filter applied when a run terminates
//   ch_state_e   - per-channel reference state
//   mode_permits - 1 when the given mode lets a run of polarity 'pol' report

package multi_run_detect_pkg;

    // Polarity filter. Encoding is fixed by the i_mode port.
    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,   // report runs of either polarity
        MODE_ONE  = 2'b01,   // report runs of 1 only
        MODE_ZERO = 2'b10,   // report runs of 0 only
        MODE_OFF  = 2'b11    // never report
    } mode_e;

    // Per-channel state. IDLE holds no reference sample. RUN holds the last
    // value and the length of the current run.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Decides whether a finished run of polarity 'pol' may be reported under
    // the given mode.
    function automatic logic mode_permits(input mode_e mode, input logic pol);
        logic ok;
        ok = 1'b0;
        case (mode)
            MODE_BOTH: ok = 1'b1;
            MODE_ONE:  ok = pol;
            MODE_ZERO: ok = ~pol;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multi_run_detect_ch.sv
// One channel of the run-length qualifier: tracks the current run and qualifies it on a value change.
// Latency: evt_* is registered and appears on the edge after the terminating sample.
// Backpressure: none; evt_vld is a one-cycle pulse that the consumer must take.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   clr                synchronous clear; drops the open run and wins over a same-cycle sample
//   mode               polarity filter, sampled live in the termination cycle
//   dn_th, up_th       inclusive run-length window, sampled live in the termination cycle
//   smp_vld, smp_dat   incoming sample
//   evt_vld            qualified-event pulse
//   evt_dat, evt_len   polarity and length of the run that ended; held between events

module run_detect_ch
    import multi_run_detect_pkg::*;
#(
    parameter int CNT_W   = 10,
    parameter int GAP_MAX = 16,
    parameter int GAP_W   = $clog2(GAP_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  mode_e            mode,
    input  logic [CNT_W-1:0] dn_th,
    input  logic [CNT_W-1:0] up_th,
    input  logic             smp_vld,
    input  logic             smp_dat,
    output logic             evt_vld,
    output logic             evt_dat,
    output logic [CNT_W-1:0] evt_len
);

    // With GAP_MAX=0 the derived width is zero. Keep a one-bit register in
    // that case so the code stays legal. The register then never moves.
    localparam int               GCW     = (GAP_W < 1) ? 1 : GAP_W;
    localparam bit               GAP_EN  = (GAP_MAX != 0);
    localparam logic [GCW-1:0]   GAP_LIM = GCW'(GAP_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ch_state_e        state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [GCW-1:0]   gap;

    logic             qualify;
    logic [GCW-1:0]   gap_nxt;

    // Qualification is evaluated against the current run before it restarts.
    // A saturated run sits at all-ones, so it can only pass when up_th is also
    // all-ones. An inverted window (dn > up) suppresses everything. The
    // range test alone would already reject everything in that case. The
    // explicit term keeps the intent visible.
    always_comb begin
        qualify = 1'b0;
        gap_nxt = gap + GCW'(1);
        if ((dn_th <= cnt) && (cnt <= up_th) && (dn_th <= up_th)) begin
            qualify = mode_permits(mode, last);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            last    <= 1'b0;
            cnt     <= '0;
            gap     <= '0;
            evt_vld <= 1'b0;
            evt_dat <= 1'b0;
            evt_len <= '0;
        end else begin
            // Pulse by default. evt_dat and evt_len hold their last value.
            evt_vld <= 1'b0;

            if (clr) begin
                // Clear wins over any sample arriving in the same cycle.
                state <= ST_IDLE;
                last  <= 1'b0;
                cnt   <= '0;
                gap   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (smp_vld) begin
                            state <= ST_RUN;
                            last  <= smp_dat;
                            cnt   <= CNT_ONE;
                            gap   <= '0;
                        end
                    end

                    ST_RUN: begin
                        if (smp_vld) begin
                            gap <= '0;
                            if (smp_dat == last) begin
                                if (cnt != CNT_MAX) begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end else begin
                                // Run ends. The changing sample becomes
                                // sample 1 of the next run.
                                if (qualify) begin
                                    evt_vld <= 1'b1;
                                    evt_dat <= last;
                                    evt_len <= cnt;
                                end
                                last <= smp_dat;
                                cnt  <= CNT_ONE;
                            end
                        end else if (GAP_EN) begin
                            // Abandon the run silently after GAP_MAX idle
                            // cycles in a row.
                            if (gap_nxt == GAP_LIM) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                                gap   <= '0;
                            end else begin
                                gap <= gap_nxt;
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_run_detect.sv
// Multi-channel run-length qualifier: reports value changes whose finished run fits a programmable window.
// Latency: o_vld/o_vld_data/o_run_len appear one edge after the terminating sample. o_cfg_err lags thresholds by one cycle.
// Backpressure: none; every o_vld pulse must be consumed in the cycle it is presented.
//
// Ports:
//   i_clk, i_rst_n          clock and asynchronous active-low reset
//   i_clr                   synchronous clear of all channels
//   i_mode                  00 both, 01 ones only, 10 zeros only, 11 off
//   i_dn_th, i_up_th        inclusive run-length window shared by all channels
//   i_vld, i_vld_data       per-channel samples
//   o_vld, o_vld_data       per-channel event pulse and polarity of the ended run
//   o_run_len               per-channel run length; channel k at [k*CNT_W +: CNT_W]
//   o_cfg_err               registered flag for i_dn_th > i_up_th

module multi_run_detect
    import multi_run_detect_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = 10,
    parameter int GAP_MAX = 16,
    parameter int GAP_W   = $clog2(GAP_MAX + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic [1:0]              i_mode,
    input  logic [CNT_W-1:0]        i_dn_th,
    input  logic [CNT_W-1:0]        i_up_th,
    input  logic [CH_NUM-1:0]       i_vld,
    input  logic [CH_NUM-1:0]       i_vld_data,
    output logic [CH_NUM-1:0]       o_vld,
    output logic [CH_NUM-1:0]       o_vld_data,
    output logic [CH_NUM*CNT_W-1:0] o_run_len,
    output logic                    o_cfg_err
);

    mode_e mode;
    assign mode = mode_e'(i_mode);

    // The flag is for reporting only. Each channel applies the dn <= up
    // test itself, on live thresholds in the termination cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= (i_dn_th > i_up_th);
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        run_detect_ch #(
            .CNT_W   (CNT_W),
            .GAP_MAX (GAP_MAX),
            .GAP_W   (GAP_W)
        ) u_ch (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .clr     (i_clr),
            .mode    (mode),
            .dn_th   (i_dn_th),
            .up_th   (i_up_th),
            .smp_vld (i_vld[k]),
            .smp_dat (i_vld_data[k]),
            .evt_vld (o_vld[k]),
            .evt_dat (o_vld_data[k]),
            .evt_len (o_run_len[k*CNT_W +: CNT_W])
        );

`ifdef ASSERT_ON
        // Each reported length was inside the window in force when the run
        // ended. That window was sampled one edge earlier.
        a_len_in_window : assert property (
            @(posedge i_clk) disable iff (!i_rst_n)
            o_vld[k] |-> (($past(i_dn_th) <= o_run_len[k*CNT_W +: CNT_W]) &&
                          (o_run_len[k*CNT_W +: CNT_W] <= $past(i_up_th)))
        );
`endif
    end

`ifdef ASSERT_ON
    // A clear must block every event on the following edge.
    a_no_evt_after_clr : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        i_clr |=> (o_vld == '0)
    );
`endif

endmodule

// File: doc/multi_run_detect.md
# multi_run_detect

Multi-channel run-length qualifier for sampled digital inputs. Each channel counts consecutive valid samples of equal value. When the value changes, the channel emits a one-cycle qualified event if the finished run length lies inside a runtime-programmable window. Compared with the single-channel fixed-threshold detector, it adds a channel count, runtime thresholds, a polarity mode, counter saturation, a gap timeout, a synchronous clear and run-length reporting. It sits between the input sampling/synchronizer stage and the control logic that consumes qualified level changes.

## Interface
- CH_NUM, 4: number of independent channels (≥1)
- CNT_W, 10: run counter width; counter saturates at 2^CNT_W−1
- GAP_MAX, 16: idle cycles without i_vld before an open run is abandoned; 0 disables the timeout
- GAP_W, $clog2(GAP_MAX+1): gap counter width (derived; do not override)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low; clock i_clk
- i_clr  in  1  synchronous clear of all channels
- i_mode  in  2  00 both polarities, 01 runs of 1 only, 10 runs of 0 only, 11 all detection off
- i_dn_th  in  CNT_W  lower bound of run length, inclusive
- i_up_th  in  CNT_W  upper bound of run length, inclusive
- i_vld  in  CH_NUM  per-channel sample valid
- i_vld_data  in  CH_NUM  per-channel sample value
- o_vld  out  CH_NUM  per-channel qualified-event pulse
- o_vld_data  out  CH_NUM  polarity of the run that just ended
- o_run_len  out  CH_NUM*CNT_W  length of the run that just ended; channel k occupies bits [k*CNT_W +: CNT_W]
- o_cfg_err  out  1  registered flag, 1 when i_dn_th > i_up_th

## Operation
- Per-channel state machine:
  - IDLE: no reference sample held.
  - RUN: holds last value, cnt and gap.
- IDLE, i_vld=1: go to RUN; last ← data; cnt ← 1; gap ← 0.
- RUN, i_vld=1, data == last: cnt ← cnt+1, saturating at all-ones; gap ← 0.
- RUN, i_vld=1, data != last: the run terminates.
  - Evaluate the event.
  - Then restart: last ← data; cnt ← 1; gap ← 0.
  - The changing sample is counted as sample 1 of the new run.
- RUN, i_vld=0: gap ← gap+1.
  - If GAP_MAX≠0 and gap+1 == GAP_MAX: go to IDLE, no event.
  - With GAP_MAX=0, gap is not used.
- Event condition at termination, all of:
  - i_dn_th ≤ cnt ≤ i_up_th;
  - dn ≤ up, i.e. no config error;
  - the mode permits polarity `last` (01 needs last=1, 10 needs last=0, 11 never).
- Thresholds and mode are sampled live in the termination cycle. No shadowing.
- A saturated run qualifies only if i_up_th is all-ones.
- i_clr=1: all channels go to IDLE and cnt/gap are zeroed.
  - o_vld forced to 0 on the next edge.
  - A sample arriving in the same cycle is discarded; clear wins.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

## Timing
- Reset values:
  - o_vld, o_vld_data, o_run_len, o_cfg_err = 0.
  - All channels IDLE; cnt, gap, last = 0.
- Latency: o_vld, o_vld_data and o_run_len are registered and appear on the edge after the terminating sample.
  - o_vld is a single-cycle pulse.
  - o_vld_data and o_run_len are meaningful only while o_vld=1; otherwise they hold their last value.
- Back-to-back terminations on consecutive cycles (alternating data with dn=1) produce o_vld on every cycle.
- o_cfg_err updates one cycle after the threshold change.
- Reset asserted mid-run clears everything asynchronously. No event is emitted for the open run.
- No back-pressure: the consumer must accept every o_vld pulse.

## Structure
- Package multi_run_detect_pkg:
  - mode enum (MODE_BOTH, MODE_ONE, MODE_ZERO, MODE_OFF);
  - channel state enum (ST_IDLE, ST_RUN).
- Sub-module run_detect_ch: one channel, containing the state machine, the saturating counter, the gap counter and the output registers.
  - Instantiated CH_NUM times by a generate loop.
  - The top holds only o_cfg_err and the shared threshold/mode fan-out.
- Assertions under ASSERT_ON:
  - o_vld implies o_run_len within [dn, up];
  - onehot-free check that no o_vld is asserted in the cycle after i_clr.

## Test plan
- Run length inside the window: dn=4, up=8, mode 00; ch0 sends 1×5 then 0 → one cycle later o_vld[0]=1, o_vld_data[0]=1, run_len=5; no other channel fires.
- Window boundaries: dn=4, up=8; runs of length 3, 4, 8 and 9, each closed by a value change → events only for 4 and 8.
- Mode filtering: mode 01; ch1 sends 0×5 then 1×5 then 0 → only the run of 1s reports (run_len=5). Repeat with mode 11 → no events.
- Gap timeout: GAP_MAX=16; ch2 sends 1×5, then 16 idle cycles, then 0 → no event. With 15 idle cycles → event with run_len=5.
- Saturation and config error:
  - CNT_W=4, up=15: run of 20 ones then 0 → event with run_len=15.
  - Then set dn=9, up=3 → o_cfg_err=1 after one cycle and all events suppressed.
- Clear and reset mid-run: i_clr pulsed during a run of 6 that is then closed by a change → no event, and the next run counts from 1. Asynchronous reset during a run → all outputs 0 immediately.
